// File: rtl/execute_stage_if.sv
// Purpose:
//   Bundles the two bus-like channels of the execute stage: the decoded
//   instruction channel coming from Decode (valid/ready) and the handshaked
//   data-memory port (req/ack).
// Modports:
//   master - the surrounding system: drives the instruction fields, mem_ack
//            and mem_rdata; observes in_ready and the memory request.
//   slave  - the execute stage: accepts instructions and drives the memory
//            request.
// Signals:
//   in_valid/in_ready, uop, num_to_rhs, num, sel_p0, sel_p1, sel_in,
//   branch_cond, mem_req, mem_we, mem_addr, mem_wdata, mem_ack, mem_rdata
interface execute_stage_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 16
);
    localparam int RSEL = $clog2(NREGS);

    logic            in_valid;
    logic            in_ready;
    logic [4:0]      uop;
    logic            num_to_rhs;
    logic [XLEN-1:0] num;
    logic [RSEL-1:0] sel_p0;
    logic [RSEL-1:0] sel_p1;
    logic [RSEL-1:0] sel_in;
    logic [3:0]      branch_cond;

    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_ack;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output in_valid, uop, num_to_rhs, num, sel_p0, sel_p1, sel_in,
               branch_cond, mem_ack, mem_rdata,
        input  in_ready, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, uop, num_to_rhs, num, sel_p0, sel_p1, sel_in,
               branch_cond, mem_ack, mem_rdata,
        output in_ready, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/execute_stage.sv
// Purpose:
//   Execute stage of a small in-order core: register file, NZCV flags, ALU,
//   branch condition check, multi-cycle load/store port and a GPIO block.
//   One decoded instruction is accepted per cycle while in EXEC; loads and
//   stores park the stage in MEM until the memory acknowledges. A taken
//   branch squashes the next SHADOW accepted instructions.
// Ports:
//   clk        - clock, all state on rising edge
//   rst_n      - asynchronous active-low reset
//   bus        - execute_stage_if.slave: instruction channel + memory port
//   gpio_in    - GPIO input pins (already synchronised externally)
//   gpio_state - GPIO output register
//   flags      - {N,Z,C,V}
//   br_valid   - one-cycle pulse when a branch is taken
//   br_offset  - branch delta, valid with br_valid, otherwise 0
module execute_stage #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 16,
    parameter int NGPIO  = 32,
    parameter int SHADOW = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    execute_stage_if.slave   bus,
    input  logic [NGPIO-1:0] gpio_in,
    output logic [NGPIO-1:0] gpio_state,
    output logic [3:0]       flags,
    output logic             br_valid,
    output logic [XLEN-1:0]  br_offset
);
    localparam int RSEL = $clog2(NREGS);
    localparam int SHW  = $clog2(XLEN);

    localparam logic [0:0] ST_EXEC = 1'b0;
    localparam logic [0:0] ST_MEM  = 1'b1;

    localparam logic [4:0] UOP_ADD     = 5'd1;
    localparam logic [4:0] UOP_SUB     = 5'd2;
    localparam logic [4:0] UOP_AND     = 5'd3;
    localparam logic [4:0] UOP_OR      = 5'd4;
    localparam logic [4:0] UOP_XOR     = 5'd5;
    localparam logic [4:0] UOP_LSL     = 5'd6;
    localparam logic [4:0] UOP_LSR     = 5'd7;
    localparam logic [4:0] UOP_MOV     = 5'd8;
    localparam logic [4:0] UOP_CMP     = 5'd9;
    localparam logic [4:0] UOP_LDR     = 5'd10;
    localparam logic [4:0] UOP_STR     = 5'd11;
    localparam logic [4:0] UOP_GPIO_WR = 5'd12;
    localparam logic [4:0] UOP_GPIO_RD = 5'd13;
    localparam logic [4:0] UOP_B       = 5'd14;

    logic [XLEN-1:0]  regsQ [NREGS];
    logic [0:0]       stateQ, stateD;
    logic [3:0]       flagsQ, flagsD;
    logic [NGPIO-1:0] gpioQ, gpioD;
    logic             brValidQ, brValidD;
    logic [XLEN-1:0]  brOffsetQ, brOffsetD;
    logic [2:0]       shadowQ, shadowD;
    logic             memReqQ, memReqD;
    logic             memWeQ, memWeD;
    logic [XLEN-1:0]  memAddrQ, memAddrD;
    logic [XLEN-1:0]  memWdataQ, memWdataD;
    logic [RSEL-1:0]  memDestQ, memDestD;

    logic             accept;
    logic             execute;
    logic [XLEN-1:0]  lhs, rhs;
    logic [XLEN:0]    sumFull, diffFull;
    logic [XLEN-1:0]  aluRes;
    logic [XLEN-1:0]  gpioExt;
    logic             rfWe;
    logic [RSEL-1:0]  rfWaddr;
    logic [XLEN-1:0]  rfWdata;

    // ARM condition codes evaluated on {N,Z,C,V}; code 15 never passes.
    function automatic logic condPass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:    condPass = z;
            4'd1:    condPass = !z;
            4'd2:    condPass = cy;
            4'd3:    condPass = !cy;
            4'd4:    condPass = n;
            4'd5:    condPass = !n;
            4'd6:    condPass = v;
            4'd7:    condPass = !v;
            4'd8:    condPass = cy && !z;
            4'd9:    condPass = !cy || z;
            4'd10:   condPass = (n == v);
            4'd11:   condPass = (n != v);
            4'd12:   condPass = !z && (n == v);
            4'd13:   condPass = z || (n != v);
            4'd14:   condPass = 1'b1;
            default: condPass = 1'b0;
        endcase
    endfunction

    assign accept  = bus.in_valid && bus.in_ready;
    // Accepted instructions inside a branch shadow have no architectural effect.
    assign execute = accept && (shadowQ == 3'd0);

    assign bus.in_ready  = (stateQ == ST_EXEC);
    assign bus.mem_req   = memReqQ;
    assign bus.mem_we    = memWeQ;
    assign bus.mem_addr  = memAddrQ;
    assign bus.mem_wdata = memWdataQ;
    assign gpio_state    = gpioQ;
    assign flags         = flagsQ;
    assign br_valid      = brValidQ;
    assign br_offset     = brOffsetQ;

    // Operand selection and the shared adder/subtractor. The subtract path
    // adds the inverted rhs plus one so its carry-out is the ARM "no borrow".
    always_comb begin
        lhs      = regsQ[bus.sel_p1];
        rhs      = bus.num_to_rhs ? bus.num : regsQ[bus.sel_p0];
        sumFull  = {1'b0, lhs} + {1'b0, rhs};
        diffFull = {1'b0, lhs} + {1'b0, ~rhs} + {{XLEN{1'b0}}, 1'b1};
        gpioExt  = '0;
        gpioExt[NGPIO-1:0] = gpio_in;
    end

    // Next-state logic: instruction execution in EXEC, load/store completion
    // in MEM. Only one of the two can write the register file in a cycle
    // because nothing is accepted while in MEM.
    always_comb begin
        stateD    = stateQ;
        flagsD    = flagsQ;
        gpioD     = gpioQ;
        brValidD  = 1'b0;
        brOffsetD = '0;
        shadowD   = shadowQ;
        memReqD   = memReqQ;
        memWeD    = memWeQ;
        memAddrD  = memAddrQ;
        memWdataD = memWdataQ;
        memDestD  = memDestQ;
        aluRes    = '0;
        rfWe      = 1'b0;
        rfWaddr   = bus.sel_in;
        rfWdata   = '0;

        if (accept && (shadowQ != 3'd0)) begin
            shadowD = shadowQ - 3'd1;
        end

        if (stateQ == ST_MEM) begin
            if (bus.mem_ack) begin
                memReqD = 1'b0;
                stateD  = ST_EXEC;
                if (!memWeQ) begin
                    rfWe    = 1'b1;
                    rfWaddr = memDestQ;
                    rfWdata = bus.mem_rdata;
                end
            end
        end else if (execute) begin
            case (bus.uop)
                UOP_ADD: begin
                    aluRes  = sumFull[XLEN-1:0];
                    rfWe    = 1'b1;
                    rfWdata = aluRes;
                    flagsD  = {aluRes[XLEN-1], aluRes == '0, sumFull[XLEN],
                               (lhs[XLEN-1] == rhs[XLEN-1]) && (aluRes[XLEN-1] != lhs[XLEN-1])};
                end
                UOP_SUB, UOP_CMP: begin
                    aluRes  = diffFull[XLEN-1:0];
                    rfWe    = (bus.uop == UOP_SUB);
                    rfWdata = aluRes;
                    flagsD  = {aluRes[XLEN-1], aluRes == '0, diffFull[XLEN],
                               (lhs[XLEN-1] != rhs[XLEN-1]) && (aluRes[XLEN-1] != lhs[XLEN-1])};
                end
                UOP_AND, UOP_OR, UOP_XOR, UOP_LSL, UOP_LSR: begin
                    case (bus.uop)
                        UOP_AND: aluRes = lhs & rhs;
                        UOP_OR:  aluRes = lhs | rhs;
                        UOP_XOR: aluRes = lhs ^ rhs;
                        UOP_LSL: aluRes = lhs << rhs[SHW-1:0];
                        default: aluRes = lhs >> rhs[SHW-1:0];
                    endcase
                    rfWe    = 1'b1;
                    rfWdata = aluRes;
                    flagsD  = {aluRes[XLEN-1], aluRes == '0, flagsQ[1:0]};
                end
                UOP_MOV: begin
                    rfWe    = 1'b1;
                    rfWdata = rhs;
                end
                UOP_LDR, UOP_STR: begin
                    stateD    = ST_MEM;
                    memReqD   = 1'b1;
                    memWeD    = (bus.uop == UOP_STR);
                    memAddrD  = sumFull[XLEN-1:0];
                    memWdataD = regsQ[bus.sel_p0];
                    memDestD  = bus.sel_in;
                end
                UOP_GPIO_WR: begin
                    gpioD = sumFull[NGPIO-1:0];
                end
                UOP_GPIO_RD: begin
                    rfWe    = 1'b1;
                    rfWdata = gpioExt;
                end
                UOP_B: begin
                    if (condPass(bus.branch_cond, flagsQ)) begin
                        brValidD  = 1'b1;
                        brOffsetD = bus.num;
                        shadowD   = 3'(SHADOW);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Control, flag, GPIO, branch and memory-port registers. Reset drops an
    // outstanding memory request immediately and abandons its writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ    <= ST_EXEC;
            flagsQ    <= '0;
            gpioQ     <= '0;
            brValidQ  <= 1'b0;
            brOffsetQ <= '0;
            shadowQ   <= '0;
            memReqQ   <= 1'b0;
            memWeQ    <= 1'b0;
            memAddrQ  <= '0;
            memWdataQ <= '0;
            memDestQ  <= '0;
        end else begin
            stateQ    <= stateD;
            flagsQ    <= flagsD;
            gpioQ     <= gpioD;
            brValidQ  <= brValidD;
            brOffsetQ <= brOffsetD;
            shadowQ   <= shadowD;
            memReqQ   <= memReqD;
            memWeQ    <= memWeD;
            memAddrQ  <= memAddrD;
            memWdataQ <= memWdataD;
            memDestQ  <= memDestD;
        end
    end

    // Register file: combinational reads above, single write port here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regsQ[i] <= '0;
            end
        end else if (rfWe) begin
            regsQ[rfWaddr] <= rfWdata;
        end
    end
endmodule

// File: tb/tb_execute_stage.sv
// Purpose:
//   Directed self-checking bench for execute_stage with default parameters
//   (XLEN=32, NREGS=16, NGPIO=32, SHADOW=1). Each instruction is driven on a
//   falling edge, transferred on the next rising edge, and its results are
//   inspected on the falling edge after that. Expected values are hand
//   computed constants.
module tb_execute_stage;
    localparam logic [4:0] NOP = 5'd0,  ADD = 5'd1,  SUB = 5'd2,  AND_ = 5'd3;
    localparam logic [4:0] OR_ = 5'd4,  XOR_ = 5'd5, LSL = 5'd6,  LSR = 5'd7;
    localparam logic [4:0] MOV = 5'd8,  CMP = 5'd9,  LDR = 5'd10, STR = 5'd11;
    localparam logic [4:0] GWR = 5'd12, GRD = 5'd13, B   = 5'd14;

    logic        clk;
    logic        rst_n;
    logic [31:0] gpio_in;
    logic [31:0] gpio_state;
    logic [3:0]  flags;
    logic        br_valid;
    logic [31:0] br_offset;

    int assertCount;
    int failCount;
    int reqCycles;

    execute_stage_if #(.XLEN(32), .NREGS(16)) bus ();

    execute_stage #(.XLEN(32), .NREGS(16), .NGPIO(32), .SHADOW(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .gpio_in   (gpio_in),
        .gpio_state(gpio_state),
        .flags     (flags),
        .br_valid  (br_valid),
        .br_offset (br_offset)
    );

    // 100 MHz-style free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] readReg(input int idx);
        return dut.regsQ[idx];
    endfunction

    // Drives one instruction from a falling edge, waits (bounded) for it to be
    // accepted, and returns on the falling edge after the transfer edge.
    task automatic applyStimulus(input logic [4:0] u, input logic ntr,
                                 input logic [31:0] n, input logic [3:0] p0,
                                 input logic [3:0] p1, input logic [3:0] rd,
                                 input logic [3:0] cond);
        bit accepted;
        accepted        = 1'b0;
        bus.uop         = u;
        bus.num_to_rhs  = ntr;
        bus.num         = n;
        bus.sel_p0      = p0;
        bus.sel_p1      = p1;
        bus.sel_in      = rd;
        bus.branch_cond = cond;
        bus.in_valid    = 1'b1;
        for (int i = 0; i < 20 && !accepted; i++) begin
            if (bus.in_ready) begin
                @(posedge clk);
                accepted = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!accepted) checkOutput("accept timeout", 64'd0, 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.uop      = NOP;
    endtask

    initial begin
        assertCount     = 0;
        failCount       = 0;
        rst_n           = 1'b0;
        gpio_in         = '0;
        bus.in_valid    = 1'b0;
        bus.uop         = NOP;
        bus.num_to_rhs  = 1'b0;
        bus.num         = '0;
        bus.sel_p0      = '0;
        bus.sel_p1      = '0;
        bus.sel_in      = '0;
        bus.branch_cond = '0;
        bus.mem_ack     = 1'b0;
        bus.mem_rdata   = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] reset state");
        checkOutput("reset in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("reset mem_req", 64'(bus.mem_req), 64'd0);
        checkOutput("reset flags", 64'(flags), 64'd0);
        checkOutput("reset br_valid", 64'(br_valid), 64'd0);
        checkOutput("reset gpio", 64'(gpio_state), 64'd0);

        $display("[TB] MOV / ADD with carry out");
        applyStimulus(MOV, 1'b1, 32'd5, 4'd0, 4'd0, 4'd1, 4'd0);
        checkOutput("mov r1", 64'(readReg(1)), 64'd5);
        checkOutput("mov flags", 64'(flags), 64'h0);
        applyStimulus(ADD, 1'b1, 32'hFFFF_FFFB, 4'd0, 4'd1, 4'd2, 4'd0);
        checkOutput("add r2", 64'(readReg(2)), 64'd0);
        checkOutput("add flags", 64'(flags), 64'b0110);

        $display("[TB] CMP + taken branch with shadow");
        applyStimulus(CMP, 1'b1, 32'd5, 4'd0, 4'd1, 4'd7, 4'd0);
        checkOutput("cmp flags", 64'(flags), 64'b0110);
        checkOutput("cmp no write", 64'(readReg(7)), 64'd0);
        applyStimulus(B, 1'b1, 32'd8, 4'd0, 4'd0, 4'd0, 4'd0);
        checkOutput("beq br_valid", 64'(br_valid), 64'd1);
        checkOutput("beq br_offset", 64'(br_offset), 64'd8);
        applyStimulus(ADD, 1'b1, 32'd1, 4'd0, 4'd1, 4'd3, 4'd0);
        checkOutput("pulse ends", 64'(br_valid), 64'd0);
        checkOutput("offset cleared", 64'(br_offset), 64'd0);
        checkOutput("squashed r3", 64'(readReg(3)), 64'd0);
        applyStimulus(MOV, 1'b1, 32'd7, 4'd0, 4'd0, 4'd3, 4'd0);
        checkOutput("post-shadow r3", 64'(readReg(3)), 64'd7);

        $display("[TB] branch not taken");
        applyStimulus(B, 1'b1, 32'h20, 4'd0, 4'd0, 4'd0, 4'd1);
        checkOutput("bne not taken", 64'(br_valid), 64'd0);
        applyStimulus(MOV, 1'b1, 32'd9, 4'd0, 4'd0, 4'd8, 4'd0);
        checkOutput("no shadow r8", 64'(readReg(8)), 64'd9);

        $display("[TB] SUB borrow, ADD overflow, logic/shift ops");
        applyStimulus(SUB, 1'b1, 32'd6, 4'd0, 4'd1, 4'd6, 4'd0);
        checkOutput("sub r6", 64'(readReg(6)), 64'hFFFF_FFFF);
        checkOutput("sub flags", 64'(flags), 64'b1000);
        applyStimulus(MOV, 1'b1, 32'h7FFF_FFFF, 4'd0, 4'd0, 4'd9, 4'd0);
        applyStimulus(ADD, 1'b1, 32'd1, 4'd0, 4'd9, 4'd10, 4'd0);
        checkOutput("ovf r10", 64'(readReg(10)), 64'h8000_0000);
        checkOutput("ovf flags", 64'(flags), 64'b1001);
        applyStimulus(LSL, 1'b1, 32'd4, 4'd0, 4'd1, 4'd11, 4'd0);
        checkOutput("lsl r11", 64'(readReg(11)), 64'h50);
        checkOutput("lsl flags", 64'(flags), 64'b0001);
        applyStimulus(LSR, 1'b1, 32'd30, 4'd0, 4'd9, 4'd12, 4'd0);
        checkOutput("lsr r12", 64'(readReg(12)), 64'd1);
        applyStimulus(XOR_, 1'b0, 32'd0, 4'd1, 4'd1, 4'd13, 4'd0);
        checkOutput("xor r13", 64'(readReg(13)), 64'd0);
        checkOutput("xor flags", 64'(flags), 64'b0101);

        $display("[TB] store with 3-cycle ack");
        applyStimulus(STR, 1'b1, 32'h40, 4'd1, 4'd0, 4'd0, 4'd0);
        checkOutput("str we", 64'(bus.mem_we), 64'd1);
        checkOutput("str addr", 64'(bus.mem_addr), 64'h40);
        checkOutput("str wdata", 64'(bus.mem_wdata), 64'd5);
        reqCycles = 0;
        for (int k = 1; k <= 3; k++) begin
            if (bus.mem_req) reqCycles++;
            checkOutput("str in_ready low", 64'(bus.in_ready), 64'd0);
            if (k == 3) bus.mem_ack = 1'b1;
            @(negedge clk);
        end
        bus.mem_ack = 1'b0;
        checkOutput("str req cycles", 64'(reqCycles), 64'd3);
        checkOutput("str req dropped", 64'(bus.mem_req), 64'd0);
        checkOutput("str in_ready back", 64'(bus.in_ready), 64'd1);

        $display("[TB] load with immediate ack");
        applyStimulus(LDR, 1'b1, 32'h80, 4'd0, 4'd0, 4'd4, 4'd0);
        checkOutput("ldr req", 64'(bus.mem_req), 64'd1);
        checkOutput("ldr we", 64'(bus.mem_we), 64'd0);
        checkOutput("ldr stall", 64'(bus.in_ready), 64'd0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        checkOutput("ldr r4", 64'(readReg(4)), 64'hDEAD_BEEF);
        checkOutput("ldr in_ready", 64'(bus.in_ready), 64'd1);

        $display("[TB] GPIO write / read");
        gpio_in = 32'h3C;
        applyStimulus(GWR, 1'b1, 32'hA5, 4'd0, 4'd0, 4'd0, 4'd0);
        checkOutput("gpio_state", 64'(gpio_state), 64'hA5);
        applyStimulus(GRD, 1'b1, 32'd0, 4'd0, 4'd0, 4'd5, 4'd0);
        checkOutput("gpio read r5", 64'(readReg(5)), 64'h3C);

        $display("[TB] stall does not consume shadow");
        applyStimulus(B, 1'b1, 32'd4, 4'd0, 4'd0, 4'd0, 4'd14);
        checkOutput("bal taken", 64'(br_valid), 64'd1);
        checkOutput("bal offset", 64'(br_offset), 64'd4);
        repeat (2) @(negedge clk);
        applyStimulus(MOV, 1'b1, 32'd1, 4'd0, 4'd0, 4'd14, 4'd0);
        checkOutput("stall squash r14", 64'(readReg(14)), 64'd0);
        applyStimulus(MOV, 1'b1, 32'd2, 4'd0, 4'd0, 4'd14, 4'd0);
        checkOutput("after shadow r14", 64'(readReg(14)), 64'd2);

        $display("[TB] reset during outstanding load");
        applyStimulus(LDR, 1'b1, 32'h100, 4'd0, 4'd0, 4'd15, 4'd0);
        checkOutput("pre-reset req", 64'(bus.mem_req), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async req drop", 64'(bus.mem_req), 64'd0);
        checkOutput("async in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset dest r15", 64'(readReg(15)), 64'd0);
        checkOutput("post-reset in_ready", 64'(bus.in_ready), 64'd1);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end
endmodule
